// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer for the RV32I core.
//
// Sits between execute and the CSR file. In IDLE it samples the exception and
// MRET requests of the non-bubble instruction in execute and then runs a
// fixed sequence:
//   trap: TRAP_COMMIT (CSR strobes) -> FLUSH x FLUSH_CYCLES -> REDIRECT to mtvec
//   MRET:                              FLUSH x FLUSH_CYCLES -> REDIRECT to mepc
//
// Ports:
//   clk, reset                async active-high reset
//   bubble                    execute slot is empty; requests ignored
//   pc_ex, instr_ex           PC and instruction word in execute
//   fault_addr                faulting address for misaligned fetch/load/store
//   exc_*                     synchronous exception requests
//   mret                      MRET executed
//   mtvec, mepc               current CSR values
//   initiate_exception        one-cycle strobe, CSR file captures trap_pc into mepc
//   trap_pc                   PC stored into mepc
//   mcause_we, mcause, mtval  one-cycle write strobe and cause/trap value
//   flush, stall_fetch        kill younger instructions and hold fetch PC
//   redirect_valid            one-cycle strobe, load redirect_pc into fetch PC
//   redirect_pc               redirect target, word-aligned
//   busy                      sequencer not in IDLE
module trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic [31:0] pc_ex,
  input  logic [31:0] instr_ex,
  input  logic [31:0] fault_addr,
  input  logic        exc_iaddr_misaligned,
  input  logic        exc_illegal,
  input  logic        exc_ebreak,
  input  logic        exc_ecall,
  input  logic        exc_laddr_misaligned,
  input  logic        exc_saddr_misaligned,
  input  logic        mret,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        initiate_exception,
  output logic [31:0] trap_pc,
  output logic        mcause_we,
  output logic [31:0] mcause,
  output logic [31:0] mtval,
  output logic        flush,
  output logic        stall_fetch,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StTrapCommit, StFlush, StRedirect} state_e;

  // FLUSH is left when the counter reads 0, so loading N-1 gives N cycles.
  localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] target_q;

  logic        exc_any;
  logic [31:0] cause_d;
  logic [31:0] mtval_d;

  // Fixed-priority exception select; earlier branches win.
  always_comb begin
    exc_any = 1'b1;
    cause_d = '0;
    mtval_d = '0;
    if (exc_iaddr_misaligned) begin
      cause_d = 32'd0;
      mtval_d = fault_addr;
    end else if (exc_illegal) begin
      cause_d = 32'd2;
      mtval_d = instr_ex;
    end else if (exc_ebreak) begin
      cause_d = 32'd3;
      mtval_d = pc_ex;
    end else if (exc_ecall) begin
      cause_d = 32'd11;
      mtval_d = '0;
    end else if (exc_laddr_misaligned) begin
      cause_d = 32'd4;
      mtval_d = fault_addr;
    end else if (exc_saddr_misaligned) begin
      cause_d = 32'd6;
      mtval_d = fault_addr;
    end else begin
      exc_any = 1'b0;
    end
  end

  // All outputs are registered and set on the transition into the state
  // that owns them, so each one is valid for exactly that state's cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= StIdle;
      cnt_q              <= '0;
      target_q           <= '0;
      initiate_exception <= 1'b0;
      trap_pc            <= '0;
      mcause_we          <= 1'b0;
      mcause             <= '0;
      mtval              <= '0;
      flush              <= 1'b0;
      stall_fetch        <= 1'b0;
      redirect_valid     <= 1'b0;
      redirect_pc        <= '0;
      busy               <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!bubble && exc_any) begin
            // An exception takes precedence over a simultaneous MRET.
            state_q            <= StTrapCommit;
            mcause             <= cause_d;
            mtval              <= mtval_d;
            trap_pc            <= pc_ex;
            target_q           <= mtvec & 32'hFFFF_FFFC;
            initiate_exception <= 1'b1;
            mcause_we          <= 1'b1;
            flush              <= 1'b1;
            stall_fetch        <= 1'b1;
            busy               <= 1'b1;
          end else if (!bubble && mret) begin
            state_q     <= StFlush;
            cnt_q       <= FlushInit;
            target_q    <= mepc & 32'hFFFF_FFFC;
            flush       <= 1'b1;
            stall_fetch <= 1'b1;
            busy        <= 1'b1;
          end
        end
        StTrapCommit: begin
          state_q            <= StFlush;
          cnt_q              <= FlushInit;
          initiate_exception <= 1'b0;
          mcause_we          <= 1'b0;
        end
        StFlush: begin
          if (cnt_q == 4'd0) begin
            state_q        <= StRedirect;
            redirect_valid <= 1'b1;
            redirect_pc    <= target_q;
            flush          <= 1'b0;
            stall_fetch    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StRedirect: begin
          state_q        <= StIdle;
          redirect_valid <= 1'b0;
          busy           <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios followed by random
// traffic, all checked every cycle against a timeline model of the sequencer.
module tb_trap_ctrl;

  localparam int unsigned F = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        bubble;
  logic [31:0] pc_ex, instr_ex, fault_addr, mtvec, mepc;
  logic        exc_iaddr_misaligned, exc_illegal, exc_ebreak, exc_ecall;
  logic        exc_laddr_misaligned, exc_saddr_misaligned, mret;
  logic        initiate_exception, mcause_we, flush, stall_fetch, redirect_valid, busy;
  logic [31:0] trap_pc, mcause, mtval, redirect_pc;

  trap_ctrl #(.FLUSH_CYCLES(F)) dut (
    .clk                  (clk),
    .reset                (reset),
    .bubble               (bubble),
    .pc_ex                (pc_ex),
    .instr_ex             (instr_ex),
    .fault_addr           (fault_addr),
    .exc_iaddr_misaligned (exc_iaddr_misaligned),
    .exc_illegal          (exc_illegal),
    .exc_ebreak           (exc_ebreak),
    .exc_ecall            (exc_ecall),
    .exc_laddr_misaligned (exc_laddr_misaligned),
    .exc_saddr_misaligned (exc_saddr_misaligned),
    .mret                 (mret),
    .mtvec                (mtvec),
    .mepc                 (mepc),
    .initiate_exception   (initiate_exception),
    .trap_pc              (trap_pc),
    .mcause_we            (mcause_we),
    .mcause               (mcause),
    .mtval                (mtval),
    .flush                (flush),
    .stall_fetch          (stall_fetch),
    .redirect_valid       (redirect_valid),
    .redirect_pc          (redirect_pc),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_init  = 0;  // initiate_exception pulses seen

  // Model: the sequence is a timeline relative to the acceptance cycle.
  int          m_kind  = 0;  // 0 none, 1 trap, 2 mret
  int          m_start = 0;
  int          m_free  = 0;  // first cycle a new request may be accepted
  logic [31:0] m_cause = '0, m_tval = '0, m_tpc = '0, m_target = '0, m_rpc = '0;

  // Priority order, highest first: iaddr, illegal, ebreak, ecall, laddr, saddr.
  int unsigned cause_tab [6] = '{0, 2, 3, 11, 4, 6};
  int unsigned tval_sel  [6] = '{0, 1, 2, 3, 0, 0};  // 0 fault, 1 instr, 2 pc, 3 zero

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    int   d;
    logic ie, fl, rv, bz;
    d  = cyc - m_start;
    ie = 1'b0; fl = 1'b0; rv = 1'b0; bz = 1'b0;
    if (m_kind == 1) begin
      ie = (d == 1);
      fl = (d >= 1) && (d <= int'(F) + 1);
      rv = (d == int'(F) + 2);
      bz = (d >= 1) && (d <= int'(F) + 2);
    end else if (m_kind == 2) begin
      fl = (d >= 1) && (d <= int'(F));
      rv = (d == int'(F) + 1);
      bz = (d >= 1) && (d <= int'(F) + 1);
    end
    if (rv) m_rpc = m_target;
    if (initiate_exception) n_init++;
    check_eq("initiate_exception", 32'(initiate_exception), 32'(ie));
    check_eq("mcause_we", 32'(mcause_we), 32'(ie));
    check_eq("flush", 32'(flush), 32'(fl));
    check_eq("stall_fetch", 32'(stall_fetch), 32'(fl));
    check_eq("redirect_valid", 32'(redirect_valid), 32'(rv));
    check_eq("busy", 32'(busy), 32'(bz));
    check_eq("mcause", mcause, m_cause);
    check_eq("mtval", mtval, m_tval);
    check_eq("trap_pc", trap_pc, m_tpc);
    check_eq("redirect_pc", redirect_pc, m_rpc);
  endtask

  // exc bits: [5] iaddr [4] illegal [3] ebreak [2] ecall [1] laddr [0] saddr
  task automatic run_cycle(input logic b, input logic [5:0] exc, input logic mr,
                           input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] fa, input logic [31:0] tv,
                           input logic [31:0] ep);
    @(negedge clk);
    cyc++;
    check_outputs();
    bubble = b;
    {exc_iaddr_misaligned, exc_illegal, exc_ebreak, exc_ecall,
     exc_laddr_misaligned, exc_saddr_misaligned} = exc;
    mret = mr; pc_ex = pc; instr_ex = ins; fault_addr = fa; mtvec = tv; mepc = ep;
    if (cyc >= m_free && !b) begin
      if (exc != 6'd0) begin
        for (int i = 0; i < 6; i++) begin
          if (exc[5-i]) begin
            m_cause = cause_tab[i];
            case (tval_sel[i])
              0: m_tval = fa;
              1: m_tval = ins;
              2: m_tval = pc;
              default: m_tval = '0;
            endcase
            break;
          end
        end
        m_kind = 1; m_start = cyc; m_free = cyc + int'(F) + 3;
        m_tpc = pc; m_target = {tv[31:2], 2'b00};
      end else if (mr) begin
        m_kind = 2; m_start = cyc; m_free = cyc + int'(F) + 2;
        m_target = {ep[31:2], 2'b00};
      end
    end
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 6'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic zero_inputs();
    bubble = 1'b0; pc_ex = '0; instr_ex = '0; fault_addr = '0; mtvec = '0; mepc = '0;
    {exc_iaddr_misaligned, exc_illegal, exc_ebreak, exc_ecall,
     exc_laddr_misaligned, exc_saddr_misaligned, mret} = 7'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"}, 32'({initiate_exception, mcause_we, flush, stall_fetch,
                                  redirect_valid, busy}), 32'd0);
    check_eq({tag, "_trap_pc"}, trap_pc, 32'd0);
    check_eq({tag, "_mcause"}, mcause, 32'd0);
    check_eq({tag, "_mtval"}, mtval, 32'd0);
    check_eq({tag, "_redirect_pc"}, redirect_pc, 32'd0);
  endtask

  initial begin
    int s;
    logic [5:0] exc;
    zero_inputs();
    reset = 1'b1;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Illegal instruction: redirect to aligned mtvec at N+2+F.
    run_cycle(1'b0, 6'b010000, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'h203, 32'h0);
    s = cyc;
    run_idle(1);
    check_eq("illegal_mcause", mcause, 32'd2);
    check_eq("illegal_mtval", mtval, 32'hFFFF_FFFF);
    check_eq("illegal_trap_pc", trap_pc, 32'h100);
    run_idle(int'(F) + 1);
    check_eq("illegal_latency", 32'(cyc - s), 32'(F + 2));
    check_eq("illegal_redirect_pc", redirect_pc, 32'h200);
    run_idle(2);

    // Priority: iaddr beats illegal and ecall; one initiate pulse only.
    n_init = 0;
    run_cycle(1'b0, 6'b110100, 1'b0, 32'h300, 32'h1234, 32'h102, 32'h80, 32'h0);
    run_idle(int'(F) + 4);
    check_eq("prio_mcause", mcause, 32'd0);
    check_eq("prio_mtval", mtval, 32'h102);
    check_eq("prio_init_pulses", 32'(n_init), 32'd1);

    // MRET: no CSR strobes, mcause kept, redirect at N+1+F.
    n_init = 0;
    run_cycle(1'b0, 6'd0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h80, 32'h444);
    run_idle(int'(F) + 2);
    check_eq("mret_mcause_kept", mcause, 32'd0);
    check_eq("mret_init_pulses", 32'(n_init), 32'd0);
    check_eq("mret_redirect_pc", redirect_pc, 32'h444);

    // Bubble gating, ecall ignored during FLUSH, accepted right after REDIRECT.
    run_cycle(1'b1, 6'b000100, 1'b0, 32'h500, 32'h0, 32'h0, 32'h80, 32'h0);
    run_cycle(1'b0, 6'b001000, 1'b0, 32'h600, 32'h0, 32'h0, 32'h90, 32'h0);
    run_idle(1);
    run_cycle(1'b0, 6'b000100, 1'b0, 32'h700, 32'h0, 32'h0, 32'hA0, 32'h0);
    run_idle(int'(F));
    run_cycle(1'b0, 6'b000100, 1'b0, 32'h800, 32'h0, 32'h0, 32'hB0, 32'h0);
    run_idle(1);
    check_eq("after_redirect_mcause", mcause, 32'd11);
    check_eq("after_redirect_trap_pc", trap_pc, 32'h800);
    run_idle(int'(F) + 3);

    // ecall with mret: trap wins, redirect to mtvec.
    run_cycle(1'b0, 6'b000100, 1'b1, 32'h80, 32'h0, 32'h0, 32'hC4, 32'h999);
    run_idle(int'(F) + 3);
    check_eq("ecall_mret_trap_pc", trap_pc, 32'h80);
    check_eq("ecall_mret_redirect_pc", redirect_pc, 32'hC4);

    // Reset mid-FLUSH abandons the trap; no redirect follows.
    run_cycle(1'b0, 6'b000010, 1'b0, 32'h900, 32'h0, 32'h44, 32'hD0, 32'h0);
    run_idle(2);
    @(negedge clk);
    zero_inputs();
    reset = 1'b1;
    #1;
    check_all_zero("midflush_reset");
    @(negedge clk);
    reset = 1'b0;
    m_kind = 0; m_free = 0;
    m_cause = '0; m_tval = '0; m_tpc = '0; m_target = '0; m_rpc = '0;
    run_idle(int'(F) + 4);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 6; k++) exc[k] = ($urandom_range(9) == 0);
      run_cycle(($urandom_range(3) == 0), exc, ($urandom_range(5) == 0),
                $urandom, $urandom, $urandom, $urandom, $urandom);
    end
    run_idle(int'(F) + 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
